bsg_clk_out_div: RTL

BSG_CLK_OUT_DIV -- requirements
Module: bsg_clk_out_div

---
 rtl/bsg_chip_pkg.sv | 25 ++
 rtl/bsg_clk_out_div_chan.sv | 141 ++++++++++++++
 rtl/bsg_clk_out_div.sv | 73 +++++++
 3 files changed

// File: rtl/bsg_chip_pkg.sv
// Shared types and constants for the divided-clock output block.
// Holds the divisor-update record, the default divisor width and the
// per-channel state encoding used by bsg_clk_out_div_chan.
package bsg_chip_pkg;

    // Default width of a channel divisor.
    localparam int div_width_lp = 8;

    // Enough channel-select bits for the largest supported block (8 channels).
    localparam int cfg_chan_width_lp = 3;

    // One divisor-update request: target channel and new divisor N.
    typedef struct packed {
        logic [cfg_chan_width_lp-1:0] chan;
        logic [div_width_lp-1:0]      div;
    } cfg_s;

    // Channel run state. DRAIN finishes a high phase after the enable drops.
    typedef enum logic [1:0] {
        CHAN_IDLE  = 2'd0,
        CHAN_RUN   = 2'd1,
        CHAN_DRAIN = 2'd2
    } chan_state_e;

endpackage

// File: rtl/bsg_clk_out_div_chan.sv
// One divided-clock channel: divisor counter, output flop, run/drain FSM and
// a single-entry pending-divisor slot.
// Optional feature macro: BSG_CLK_OUT_DIV_EDGE_CNT_EN adds a rising-edge
// counter on the output (edge_cnt), cleared only by reset.
// The FSM state lives in state_r so checkers can observe it directly.
module bsg_clk_out_div_chan
    import bsg_chip_pkg::*;
#(
    parameter int div_width_p = div_width_lp,
    parameter int reset_div_p = 1,
    parameter int cnt_width_p = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic                   sync,
    input  logic                   cfg_w,
    input  logic [div_width_p-1:0] cfg_div,
    output logic                   ready,
    output logic                   out
`ifdef BSG_CLK_OUT_DIV_EDGE_CNT_EN
    ,
    output logic [cnt_width_p-1:0] edge_cnt
`endif
);

    chan_state_e            state_r, state_n;
    logic [div_width_p-1:0] cnt_r, cnt_n;
    logic [div_width_p-1:0] div_r, div_n;
    logic [div_width_p-1:0] pend_r, pend_n;
    logic                   pend_v_r, pend_v_n;
    logic                   out_r, out_n;
    logic                   at_term;

    assign at_term = (cnt_r == div_r);
    assign ready   = ~pend_v_r;
    assign out     = out_r;

    // Next-state logic: sync overrides everything, then per-state counting.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        div_n    = div_r;
        pend_n   = pend_r;
        pend_v_n = pend_v_r;
        out_n    = out_r;
        if (sync) begin
            // Phase-align: restart low from zero, may cut a high phase short.
            cnt_n    = '0;
            out_n    = 1'b0;
            if (pend_v_r) begin
                div_n = pend_r;
            end
            pend_v_n = 1'b0;
            state_n  = en ? CHAN_RUN : CHAN_IDLE;
        end else begin
            unique case (state_r)
                CHAN_IDLE: begin
                    cnt_n = '0;
                    out_n = 1'b0;
                    if (pend_v_r) begin
                        div_n    = pend_r;
                        pend_v_n = 1'b0;
                    end
                    if (en) begin
                        state_n = CHAN_RUN;
                    end
                end
                CHAN_RUN, CHAN_DRAIN: begin
                    if (!en && !out_r) begin
                        // Stopping during a low phase is already glitch-free.
                        state_n = CHAN_IDLE;
                        cnt_n   = '0;
                    end else begin
                        state_n = en ? CHAN_RUN : CHAN_DRAIN;
                        if (at_term) begin
                            cnt_n = '0;
                            out_n = ~out_r;
                            if (out_r) begin
                                // Falling edge: safe point to switch divisor or stop.
                                if (pend_v_r) begin
                                    div_n    = pend_r;
                                    pend_v_n = 1'b0;
                                end
                                if (!en) begin
                                    state_n = CHAN_IDLE;
                                end
                            end
                        end else begin
                            cnt_n = cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = CHAN_IDLE;
                    cnt_n   = '0;
                    out_n   = 1'b0;
                end
            endcase
        end
        if (cfg_w) begin
            pend_n   = cfg_div;
            pend_v_n = 1'b1;
        end
    end

    // Channel state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= CHAN_IDLE;
            cnt_r    <= '0;
            div_r    <= div_width_p'(reset_div_p);
            pend_r   <= '0;
            pend_v_r <= 1'b0;
            out_r    <= 1'b0;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            div_r    <= div_n;
            pend_r   <= pend_n;
            pend_v_r <= pend_v_n;
            out_r    <= out_n;
        end
    end

`ifdef BSG_CLK_OUT_DIV_EDGE_CNT_EN
    logic [cnt_width_p-1:0] edge_cnt_r;

    // Count 0->1 transitions of the output; wraps, and sync does not clear it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_cnt_r <= '0;
        end else if (!out_r && out_n) begin
            edge_cnt_r <= edge_cnt_r + 1'b1;
        end
    end

    assign edge_cnt = edge_cnt_r;
`endif

endmodule

// File: rtl/bsg_clk_out_div.sv
// Multi-channel divided-clock generator. Each channel produces a 50% duty
// clock of period 2*(N+1) cycles from registered flops, with glitch-free
// start/stop and divisor changes deferred to the falling edge.
// Optional feature macro: BSG_CLK_OUT_DIV_EDGE_CNT_EN adds port cnt_o with
// one rising-edge counter per channel.
//
// Divisor-update handshake: a request is accepted on a clock edge where
// cfg_v_i and cfg_ready_o are both high. cfg_ready_o depends only on whether
// the addressed channel already holds an unapplied divisor; out-of-range
// channel numbers always read ready and are dropped without effect.
module bsg_clk_out_div
    import bsg_chip_pkg::*;
#(
    parameter int num_out_p   = 2,
    parameter int div_width_p = div_width_lp,
    parameter int reset_div_p = 1,
    parameter int cnt_width_p = 16
) (
    input  logic                                              clk_i,
    input  logic                                              reset_n_i,
    input  logic [num_out_p-1:0]                              en_i,
    input  logic                                              cfg_v_i,
    input  logic [((num_out_p > 1) ? $clog2(num_out_p) : 1)-1:0] cfg_chan_i,
    input  logic [div_width_p-1:0]                            cfg_div_i,
    output logic                                              cfg_ready_o,
    input  logic                                              sync_i,
    output logic [num_out_p-1:0]                              div_o
`ifdef BSG_CLK_OUT_DIV_EDGE_CNT_EN
    ,
    output logic [num_out_p*cnt_width_p-1:0]                  cnt_o
`endif
);

    localparam int cw_lp  = (num_out_p > 1) ? $clog2(num_out_p) : 1;
    localparam int pad_lp = 1 << cw_lp;

    logic [num_out_p-1:0] chan_ready;
    logic [pad_lp-1:0]    ready_pad;

    // Unused channel numbers read as always-ready so stray requests complete.
    always_comb begin
        ready_pad                = '1;
        ready_pad[num_out_p-1:0] = chan_ready;
    end

    assign cfg_ready_o = ready_pad[cfg_chan_i];

    for (genvar g = 0; g < num_out_p; g++) begin : g_chan
        logic cfg_w;

        assign cfg_w = cfg_v_i & cfg_ready_o & (cfg_chan_i == cw_lp'(g));

        bsg_clk_out_div_chan #(
            .div_width_p(div_width_p),
            .reset_div_p(reset_div_p),
            .cnt_width_p(cnt_width_p)
        ) u_chan (
            .clk     (clk_i),
            .reset_n (reset_n_i),
            .en      (en_i[g]),
            .sync    (sync_i),
            .cfg_w   (cfg_w),
            .cfg_div (cfg_div_i),
            .ready   (chan_ready[g]),
            .out     (div_o[g])
`ifdef BSG_CLK_OUT_DIV_EDGE_CNT_EN
            ,
            .edge_cnt(cnt_o[g*cnt_width_p +: cnt_width_p])
`endif
        );
    end

endmodule
